// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULT/DIV sequencer: state encoding, HI/LO source
// selectors and exception cause codes.
package muldiv_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StMStart = 3'd1,
    StMRun   = 3'd2,
    StDStart = 3'd3,
    StDRun   = 3'd4,
    StWb     = 3'd5,
    StExc    = 3'd6
  } state_e;

  localparam logic SEL_MULT = 1'b0;
  localparam logic SEL_DIV  = 1'b1;

  localparam logic CAUSE_DZ = 1'b0;
  localparam logic CAUSE_TO = 1'b1;

  function automatic logic is_run(input state_e st);
    return (st == StMRun) || (st == StDRun);
  endfunction

endpackage

// File: rtl/muldiv_timer.sv
// Cycle counter for the RUN states; flags the last cycle before a timeout.
module muldiv_timer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign tc_o = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer for the shared multiplier/divider: latches operands, pulses the unit
// start, waits for its end handshake and drives HI/LO writeback or an exception.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_mult,
  input  logic              req_div,
  input  logic              flush,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              mult_end,
  input  logic              div_end,
  input  logic              div_by_zero,
  output logic [DATA_W-1:0] unit_a,
  output logic [DATA_W-1:0] unit_b,
  output logic              mult_start,
  output logic              div_start,
  output logic              hi_load,
  output logic              lo_load,
  output logic              hi_ctrl,
  output logic              lo_ctrl,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic              timeout
);

  state_e state_q, state_d;
  logic   sel_d;
  logic   cause_d;
  logic   accept;
  logic   tc;

  muldiv_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  ((state_q == StMStart) || (state_q == StDStart)),
    .en_i   (is_run(state_q)),
    .tc_o   (tc)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = SEL_MULT;
    cause_d = CAUSE_DZ;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_mult) begin
          state_d = StMStart;
          accept  = 1'b1;
        end else if (req_div) begin
          if (op_b != '0) begin
            state_d = StDStart;
            accept  = 1'b1;
          end else begin
            state_d = StExc;
            cause_d = CAUSE_DZ;
          end
        end
      end
      StMStart: state_d = StMRun;
      StDStart: state_d = StDRun;
      StMRun: begin
        if (mult_end) begin
          state_d = StWb;
          sel_d   = SEL_MULT;
        end else if (tc) begin
          state_d = StExc;
          cause_d = CAUSE_TO;
        end
      end
      StDRun: begin
        // A late zero flag wins over the end handshake: the quotient is garbage.
        if (div_by_zero) begin
          state_d = StExc;
          cause_d = CAUSE_DZ;
        end else if (div_end) begin
          state_d = StWb;
          sel_d   = SEL_DIV;
        end else if (tc) begin
          state_d = StExc;
          cause_d = CAUSE_TO;
        end
      end
      StWb:    state_d = StIdle;
      StExc:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      unit_a     <= '0;
      unit_b     <= '0;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      hi_load    <= 1'b0;
      lo_load    <= 1'b0;
      hi_ctrl    <= 1'b0;
      lo_ctrl    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        unit_a <= op_a;
        unit_b <= op_b;
      end
      mult_start <= (state_d == StMStart);
      div_start  <= (state_d == StDStart);
      hi_load    <= (state_d == StWb);
      lo_load    <= (state_d == StWb);
      done       <= (state_d == StWb);
      // Selects hold outside WB so HI/LO stay readable through the mux.
      if (state_d == StWb) begin
        hi_ctrl <= sel_d;
        lo_ctrl <= sel_d;
      end
      div_zero <= (state_d == StExc) && (cause_d == CAUSE_DZ);
      timeout  <= (state_d == StExc) && (cause_d == CAUSE_TO);
      busy     <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with TIMEOUT=4; checks the packed control outputs
// and latched operands cycle by cycle against hand-computed values.
module tb_muldiv_seq;

  localparam int unsigned DATA_W = 32;

  localparam logic [9:0] B_BUSY = 10'h200;
  localparam logic [9:0] B_MS   = 10'h100;
  localparam logic [9:0] B_DS   = 10'h080;
  localparam logic [9:0] B_HL   = 10'h040;
  localparam logic [9:0] B_LL   = 10'h020;
  localparam logic [9:0] B_HC   = 10'h010;
  localparam logic [9:0] B_LC   = 10'h008;
  localparam logic [9:0] B_DONE = 10'h004;
  localparam logic [9:0] B_DZ   = 10'h002;
  localparam logic [9:0] B_TO   = 10'h001;
  localparam logic [9:0] WB_M   = B_BUSY | B_HL | B_LL | B_DONE;
  localparam logic [9:0] SELS   = B_HC | B_LC;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_mult = 1'b0;
  logic              req_div = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] op_a = '0;
  logic [DATA_W-1:0] op_b = '0;
  logic              mult_end = 1'b0;
  logic              div_end = 1'b0;
  logic              div_by_zero = 1'b0;
  logic [DATA_W-1:0] unit_a, unit_b;
  logic mult_start, div_start, hi_load, lo_load, hi_ctrl, lo_ctrl;
  logic busy, done, div_zero, timeout;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(
    .DATA_W  (DATA_W),
    .TIMEOUT (4),
    .CNT_W   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_mult    (req_mult),
    .req_div     (req_div),
    .flush       (flush),
    .op_a        (op_a),
    .op_b        (op_b),
    .mult_end    (mult_end),
    .div_end     (div_end),
    .div_by_zero (div_by_zero),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .mult_start  (mult_start),
    .div_start   (div_start),
    .hi_load     (hi_load),
    .lo_load     (lo_load),
    .hi_ctrl     (hi_ctrl),
    .lo_ctrl     (lo_ctrl),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {busy, mult_start, div_start, hi_load, lo_load, hi_ctrl, lo_ctrl,
            done, div_zero, timeout};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Async reset asserted between edges
    #2 rst = 1'b0;
    #1;
    check("reset_outs", 32'(outs()), 32'(10'h000));
    check("reset_unit_a", unit_a, 32'd0);
    check("reset_unit_b", unit_b, 32'd0);
    #5 rst = 1'b1;
    tick();
    check("idle_after_reset", 32'(outs()), 32'(10'h000));

    // MULT 7 x 5, mult_end three cycles after mult_start
    req_mult = 1'b1; op_a = 32'd7; op_b = 32'd5;
    tick();
    req_mult = 1'b0;
    check("mul_start", 32'(outs()), 32'(B_BUSY | B_MS));
    check("mul_unit_a", unit_a, 32'd7);
    check("mul_unit_b", unit_b, 32'd5);
    tick();
    check("mul_run0", 32'(outs()), 32'(B_BUSY));
    tick();
    check("mul_run1", 32'(outs()), 32'(B_BUSY));
    tick();
    check("mul_run2", 32'(outs()), 32'(B_BUSY));
    mult_end = 1'b1;
    tick();
    mult_end = 1'b0;
    check("mul_wb", 32'(outs()), 32'(WB_M));
    tick();
    check("mul_idle", 32'(outs()), 32'(10'h000));

    // DIV 100 / 0: immediate exception, divider never started
    req_div = 1'b1; op_a = 32'd100; op_b = 32'd0;
    tick();
    req_div = 1'b0;
    check("dz_exc", 32'(outs()), 32'(B_BUSY | B_DZ));
    check("dz_no_latch", unit_a, 32'd7);
    tick();
    check("dz_idle", 32'(outs()), 32'(10'h000));

    // DIV 50 / 3 with zero flag raised together with div_end
    req_div = 1'b1; op_a = 32'd50; op_b = 32'd3;
    tick();
    req_div = 1'b0;
    check("ldz_start", 32'(outs()), 32'(B_BUSY | B_DS));
    check("ldz_unit_b", unit_b, 32'd3);
    tick();
    check("ldz_run", 32'(outs()), 32'(B_BUSY));
    div_by_zero = 1'b1; div_end = 1'b1;
    tick();
    div_by_zero = 1'b0; div_end = 1'b0;
    check("ldz_exc", 32'(outs()), 32'(B_BUSY | B_DZ));
    tick();
    check("ldz_idle", 32'(outs()), 32'(10'h000));

    // Normal DIV 9 / 2: selects go to 1 and hold after WB
    req_div = 1'b1; op_a = 32'd9; op_b = 32'd2;
    tick();
    req_div = 1'b0;
    check("div_start", 32'(outs()), 32'(B_BUSY | B_DS));
    tick();
    div_end = 1'b1;
    tick();
    div_end = 1'b0;
    check("div_wb", 32'(outs()), 32'(WB_M | SELS));
    tick();
    check("div_idle_hold", 32'(outs()), 32'(SELS));

    // Back-to-back request right after WB, then timeout with no mult_end
    req_mult = 1'b1; op_a = 32'd1; op_b = 32'd1;
    tick();
    req_mult = 1'b0;
    check("to_start", 32'(outs()), 32'(B_BUSY | B_MS | SELS));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_run", 32'(outs()), 32'(B_BUSY | SELS));
    end
    tick();
    check("to_exc", 32'(outs()), 32'(B_BUSY | B_TO | SELS));
    tick();
    check("to_idle", 32'(outs()), 32'(SELS));

    // Flush in M_RUN, late mult_end ignored
    req_mult = 1'b1; op_a = 32'd3; op_b = 32'd4;
    tick();
    req_mult = 1'b0;
    tick();
    check("fl_run", 32'(outs()), 32'(B_BUSY | SELS));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_idle", 32'(outs()), 32'(SELS));
    mult_end = 1'b1;
    tick();
    mult_end = 1'b0;
    check("fl_no_done", 32'(outs()), 32'(SELS));

    // Both requests: multiply wins; req_div while busy ignored
    req_mult = 1'b1; req_div = 1'b1; op_a = 32'd6; op_b = 32'd2;
    tick();
    req_mult = 1'b0; req_div = 1'b0;
    check("arb_mult", 32'(outs()), 32'(B_BUSY | B_MS | SELS));
    tick();
    req_div = 1'b1; op_a = 32'd11; op_b = 32'd12;
    tick();
    req_div = 1'b0;
    check("busy_ignore", 32'(outs()), 32'(B_BUSY | SELS));
    check("busy_unit_a", unit_a, 32'd6);
    mult_end = 1'b1;
    tick();
    mult_end = 1'b0;
    check("arb_wb", 32'(outs()), 32'(WB_M));
    tick();
    check("arb_idle", 32'(outs()), 32'(10'h000));

    // Async reset in the middle of D_RUN
    req_div = 1'b1; op_a = 32'd20; op_b = 32'd4;
    tick();
    req_div = 1'b0;
    tick();
    check("rst_drun", 32'(outs()), 32'(B_BUSY));
    #2 rst = 1'b0;
    #1;
    check("rst_async_outs", 32'(outs()), 32'(10'h000));
    check("rst_async_unit_a", unit_a, 32'd0);
    #1 rst = 1'b1;
    req_mult = 1'b1; op_a = 32'd2; op_b = 32'd3;
    tick();
    req_mult = 1'b0;
    check("post_rst_start", 32'(outs()), 32'(B_BUSY | B_MS));
    tick();
    mult_end = 1'b1;
    tick();
    mult_end = 1'b0;
    check("post_rst_wb", 32'(outs()), 32'(WB_M));
    check("post_rst_unit_b", unit_b, 32'd3);
    tick();
    check("post_rst_idle", 32'(outs()), 32'(10'h000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
